tdc_sequencer: RTL and testbench

- Controller for one TDC measurement channel in the Sigma Delta DAQ.
- Sequences one measurement: fires the start pulse into the differential pulse / delay-line stage, counts coarse clock cycles until the stop event, then collects the fine code from the delay-line encoder.
- Clears the TDC front end after each measurement and presents {coarse, fine} on a valid/ready result port for the decimation/readout logic.

---
 rtl/tdc_sequencer.sv | 169 ++++++++++++++++
 tb/tb_tdc_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/tdc_sequencer.sv
// Single-channel TDC measurement sequencer: start pulse, coarse count to the
// synchronized stop edge, fine-code capture, front-end clear, valid/ready result.
module tdc_sequencer #(
  parameter int COARSE_W       = 16,
  parameter int FINE_W         = 5,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int FINE_TIMEOUT   = 16,
  parameter int SYNC_STAGES    = 2,
  parameter int CLEAR_CYCLES   = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       i_enable,
  input  logic                       i_start_req,
  input  logic                       i_stop_hit,
  input  logic                       i_fine_valid,
  input  logic [FINE_W-1:0]          i_fine_code,
  output logic                       o_tdc_start,
  output logic                       o_tdc_clear,
  output logic                       o_busy,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [COARSE_W+FINE_W-1:0] o_result,
  output logic                       o_timeout
);

  localparam int CNT_MAX = (FINE_TIMEOUT > CLEAR_CYCLES) ? FINE_TIMEOUT : CLEAR_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [COARSE_W-1:0] COARSE_LAST = COARSE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]    FINE_LAST   = CNT_W'(FINE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]    CLEAR_LAST  = CNT_W'(CLEAR_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_COUNT     = 3'd2,
    S_WAIT_FINE = 3'd3,
    S_CLEAR     = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t                 r_state, w_next_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_stop_flag;
  logic [COARSE_W-1:0]    r_coarse, w_coarse_nxt;
  logic [FINE_W-1:0]      r_fine, w_fine_nxt;
  logic                   r_timeout, w_timeout_nxt;
  logic                   r_abort, w_abort_nxt;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
  logic                   r_tdc_start, r_tdc_clear, r_busy, r_valid;

  // Stop synchronizer; the last stage doubles as the edge-detect history bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= {SYNC_STAGES{1'b0}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_stop_hit};
    end
  end

  assign w_stop_flag = r_sync[SYNC_STAGES-2] & ~r_sync[SYNC_STAGES-1];

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and next-datapath logic.
  always_comb begin
    w_next_state  = r_state;
    w_coarse_nxt  = r_coarse;
    w_fine_nxt    = r_fine;
    w_timeout_nxt = r_timeout;
    w_abort_nxt   = r_abort;
    case (r_state)
      S_IDLE: begin
        if (i_enable && i_start_req) w_next_state = S_START;
        else                         w_next_state = S_IDLE;
      end
      S_START: begin
        w_coarse_nxt  = {COARSE_W{1'b0}};
        w_fine_nxt    = {FINE_W{1'b0}};
        w_timeout_nxt = 1'b0;
        w_abort_nxt   = !i_enable;
        if (!i_enable) w_next_state = S_CLEAR;
        else           w_next_state = S_COUNT;
      end
      S_COUNT: begin
        if (!i_enable) begin
          w_abort_nxt  = 1'b1;
          w_next_state = S_CLEAR;
        end else if (w_stop_flag) begin
          w_next_state = S_WAIT_FINE;
        end else if (r_coarse == COARSE_LAST) begin
          w_coarse_nxt  = {COARSE_W{1'b1}};
          w_fine_nxt    = {FINE_W{1'b0}};
          w_timeout_nxt = 1'b1;
          w_next_state  = S_CLEAR;
        end else begin
          w_coarse_nxt = r_coarse + COARSE_W'(1);
        end
      end
      S_WAIT_FINE: begin
        if (!i_enable) begin
          w_abort_nxt  = 1'b1;
          w_next_state = S_CLEAR;
        end else if (i_fine_valid) begin
          w_fine_nxt   = i_fine_code;
          w_next_state = S_CLEAR;
        end else if (r_cnt == FINE_LAST) begin
          w_fine_nxt    = {FINE_W{1'b1}};
          w_timeout_nxt = 1'b1;
          w_next_state  = S_CLEAR;
        end else begin
          w_next_state = S_WAIT_FINE;
        end
      end
      S_CLEAR: begin
        if (r_cnt == CLEAR_LAST) w_next_state = r_abort ? S_IDLE : S_DONE;
        else                     w_next_state = S_CLEAR;
      end
      S_DONE: begin
        if (i_ready) w_next_state = S_IDLE;
        else         w_next_state = S_DONE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
    w_cnt_nxt = (w_next_state != r_state) ? {CNT_W{1'b0}} : r_cnt + CNT_W'(1);
  end

  // Datapath and output flops; strobes follow the state being entered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_coarse    <= {COARSE_W{1'b0}};
      r_fine      <= {FINE_W{1'b0}};
      r_timeout   <= 1'b0;
      r_abort     <= 1'b0;
      r_cnt       <= {CNT_W{1'b0}};
      r_tdc_start <= 1'b0;
      r_tdc_clear <= 1'b0;
      r_busy      <= 1'b0;
      r_valid     <= 1'b0;
    end else begin
      r_coarse    <= w_coarse_nxt;
      r_fine      <= w_fine_nxt;
      r_timeout   <= w_timeout_nxt;
      r_abort     <= w_abort_nxt;
      r_cnt       <= w_cnt_nxt;
      r_tdc_start <= (w_next_state == S_START);
      r_tdc_clear <= (w_next_state == S_CLEAR);
      r_busy      <= (w_next_state != S_IDLE);
      r_valid     <= (w_next_state == S_DONE);
    end
  end

  assign o_tdc_start = r_tdc_start;
  assign o_tdc_clear = r_tdc_clear;
  assign o_busy      = r_busy;
  assign o_valid     = r_valid;
  assign o_result    = {r_coarse, r_fine};
  assign o_timeout   = r_timeout;

endmodule

// File: tb/tb_tdc_sequencer.sv
// Directed self-checking bench for tdc_sequencer (default parameters).
module tb_tdc_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_enable, i_start_req, i_stop_hit, i_fine_valid, i_ready;
  logic [4:0]  i_fine_code;
  logic        o_tdc_start, o_tdc_clear, o_busy, o_valid, o_timeout;
  logic [20:0] o_result;
  int          n_checks = 0;
  int          n_errors = 0;

  tdc_sequencer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_enable     (i_enable),
    .i_start_req  (i_start_req),
    .i_stop_hit   (i_stop_hit),
    .i_fine_valid (i_fine_valid),
    .i_fine_code  (i_fine_code),
    .o_tdc_start  (o_tdc_start),
    .o_tdc_clear  (o_tdc_clear),
    .o_busy       (o_busy),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_result     (o_result),
    .o_timeout    (o_timeout)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"},  32'(o_busy),      32'd0);
    chk({tag, "_valid"}, 32'(o_valid),     32'd0);
    chk({tag, "_clear"}, 32'(o_tdc_clear), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; i_enable = 1'b0; i_start_req = 1'b0; i_stop_hit = 1'b0;
    i_fine_valid = 1'b0; i_fine_code = 5'd0; i_ready = 1'b0;
    step(2);
    chk("rst_start",   32'(o_tdc_start), 32'd0);
    chk("rst_result",  32'(o_result),    32'd0);
    chk("rst_timeout", 32'(o_timeout),   32'd0);
    chk_idle("rst");
    reset_n = 1'b1; i_enable = 1'b1;
    step(2);

    // Nominal: stop sampled at end of COUNT cycle 10 -> coarse 11, fine 13
    i_start_req = 1'b1; step(1);
    chk("nom_start", 32'(o_tdc_start), 32'd1);
    chk("nom_busy",  32'(o_busy),      32'd1);
    i_start_req = 1'b0; step(1);
    chk("nom_start_1cyc", 32'(o_tdc_start), 32'd0);
    chk("nom_coarse0",    32'(o_result[20:5]), 32'd0);
    step(10);
    i_stop_hit = 1'b1; step(2);
    chk("nom_wait_coarse", 32'(o_result[20:5]), 32'd11);
    i_fine_valid = 1'b1; i_fine_code = 5'd13; step(1);
    i_fine_valid = 1'b0; i_stop_hit = 1'b0;
    chk("nom_clear0", 32'(o_tdc_clear), 32'd1);
    step(1);
    chk("nom_clear1", 32'(o_tdc_clear), 32'd1);
    step(1);
    chk("nom_clear_end", 32'(o_tdc_clear), 32'd0);
    chk("nom_valid",     32'(o_valid),     32'd1);
    chk("nom_result",    32'(o_result),    32'({16'd11, 5'd13}));
    chk("nom_timeout",   32'(o_timeout),   32'd0);
    i_ready = 1'b1; step(1);
    i_ready = 1'b0;
    chk_idle("nom_accept");
    step(2);

    // Missing stop: CLEAR after COUNT cycle 999
    i_start_req = 1'b1; step(1);
    i_start_req = 1'b0; step(1000);
    chk("to_last_coarse", 32'(o_result[20:5]), 32'd999);
    chk("to_last_clear",  32'(o_tdc_clear),    32'd0);
    step(1);
    chk("to_clear",   32'(o_tdc_clear), 32'd1);
    chk("to_tflag",   32'(o_timeout),   32'd1);
    step(2);
    chk("to_valid",   32'(o_valid),     32'd1);
    chk("to_result",  32'(o_result),    32'({16'hFFFF, 5'd0}));
    chk("to_timeout", 32'(o_timeout),   32'd1);
    i_ready = 1'b1; step(1);
    i_ready = 1'b0;
    chk_idle("to_accept");
    step(2);

    // Missing fine code: stop in COUNT cycle 1 -> coarse 2, 16 WAIT_FINE cycles
    i_start_req = 1'b1; step(1);
    i_start_req = 1'b0; step(1);
    i_fine_valid = 1'b1; i_fine_code = 5'd9; step(1);
    i_fine_valid = 1'b0; i_stop_hit = 1'b1; step(2);
    i_stop_hit = 1'b0; step(15);
    chk("mf_last_wait_clear", 32'(o_tdc_clear), 32'd0);
    chk("mf_last_wait_busy",  32'(o_busy),      32'd1);
    step(1);
    chk("mf_clear", 32'(o_tdc_clear), 32'd1);
    step(2);
    chk("mf_valid",   32'(o_valid),   32'd1);
    chk("mf_result",  32'(o_result),  32'({16'd2, 5'h1F}));
    chk("mf_timeout", 32'(o_timeout), 32'd1);

    // Backpressure with ignored requests in DONE
    for (int i = 0; i < 20; i++) begin
      i_start_req = i[0];
      i_enable    = (i == 7) ? 1'b0 : 1'b1;
      step(1);
      chk("bp_valid",  32'(o_valid),     32'd1);
      chk("bp_busy",   32'(o_busy),      32'd1);
      chk("bp_start",  32'(o_tdc_start), 32'd0);
      chk("bp_result", 32'(o_result),    32'({16'd2, 5'h1F}));
    end
    i_start_req = 1'b0; i_enable = 1'b1; i_ready = 1'b1; step(1);
    i_ready = 1'b0;
    chk_idle("bp_accept");
    chk("bp_no_start", 32'(o_tdc_start), 32'd0);

    // Next request honoured, then enable dropped in COUNT cycle 5
    i_start_req = 1'b1; step(1);
    chk("ab_start", 32'(o_tdc_start), 32'd1);
    i_start_req = 1'b0; step(6);
    chk("ab_coarse5", 32'(o_result[20:5]), 32'd5);
    i_enable = 1'b0; step(1);
    chk("ab_clear0", 32'(o_tdc_clear), 32'd1);
    chk("ab_valid0", 32'(o_valid),     32'd0);
    step(1);
    chk("ab_clear1", 32'(o_tdc_clear), 32'd1);
    step(1);
    chk_idle("ab_idle");
    i_enable = 1'b1; step(3);
    chk_idle("ab_later");

    // Reset asserted mid WAIT_FINE, without a clock edge
    i_start_req = 1'b1; step(1);
    i_start_req = 1'b0; step(2);
    i_stop_hit = 1'b1; step(2);
    i_stop_hit = 1'b0; step(1);
    chk("rm_busy_before", 32'(o_busy), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("rm_start",   32'(o_tdc_start), 32'd0);
    chk("rm_result",  32'(o_result),    32'd0);
    chk("rm_timeout", 32'(o_timeout),   32'd0);
    chk_idle("rm");
    step(1);
    reset_n = 1'b1; step(1);

    // Clean measurement after reset: stop in COUNT cycle 3 -> coarse 4, fine 7
    i_start_req = 1'b1; step(1);
    chk("cl_start", 32'(o_tdc_start), 32'd1);
    i_start_req = 1'b0; step(4);
    i_stop_hit = 1'b1; step(3);
    i_stop_hit = 1'b0; i_fine_valid = 1'b1; i_fine_code = 5'd7; step(1);
    i_fine_valid = 1'b0;
    chk("cl_clear", 32'(o_tdc_clear), 32'd1);
    step(2);
    chk("cl_valid",   32'(o_valid),   32'd1);
    chk("cl_result",  32'(o_result),  32'({16'd4, 5'd7}));
    chk("cl_timeout", 32'(o_timeout), 32'd0);
    i_ready = 1'b1; step(1);
    i_ready = 1'b0;
    chk_idle("cl_accept");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
